// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer wrapped around the 8-bit combinational ALU.
// Collects opcode/A/B, drives registered ALU inputs and returns the result.
module alu_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   output logic       byte_ready_o,
   output logic [7:0] alu_data0_o,
   output logic [7:0] alu_data1_o,
   output logic [2:0] alu_ctrl_o,
   input  logic [7:0] alu_result_i,
   output logic [7:0] result_o,
   output logic       err_o,
   output logic       result_valid_o,
   input  logic       result_ready_i,
   output logic       timeout_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      EXEC,
      HOLD
   } state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  data0_q, data1_q, result_q;
   logic [2:0]  ctrl_q;
   logic        inv_q, dz_q, err_q;
   logic        tmo_q, tmo_d;
   logic        collecting, abort, hs;

   always_comb begin
      collecting   = (state_q == GET_A) || (state_q == GET_B);
      abort        = collecting && (TMO != 16'd0) && (cnt_q == TMO);
      byte_ready_o = !rst_i && !abort && ((state_q == IDLE) || collecting);
      hs           = byte_valid_i && byte_ready_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               state_d = GET_A;
               cnt_d   = 16'd0;
            end
         end
         GET_A: begin
            if (abort) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end else if (hs) begin
               state_d = GET_B;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         GET_B: begin
            if (abort) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end else if (hs) begin
               state_d = EXEC;
               cnt_d   = 16'd0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         EXEC: state_d = HOLD;
         HOLD: begin
            if (result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands and opcode persist until the next command overwrites them
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q   <= 3'd0;
         inv_q    <= 1'b0;
         data0_q  <= 8'h00;
         data1_q  <= 8'h00;
         dz_q     <= 1'b0;
         result_q <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         if (hs && (state_q == IDLE)) begin
            ctrl_q <= byte_i[2:0];
            inv_q  <= (byte_i[7:3] != 5'd0) || (byte_i[2:0] > 3'd4);
         end
         if (hs && (state_q == GET_A)) data0_q <= byte_i;
         if (hs && (state_q == GET_B)) begin
            data1_q <= byte_i;
            dz_q    <= ((ctrl_q == 3'd3) || (ctrl_q == 3'd4)) && (byte_i == 8'h00);
         end
         if (state_q == EXEC) begin
            err_q    <= inv_q || dz_q;
            result_q <= (inv_q || dz_q) ? 8'h00 : alu_result_i;
         end
      end
   end

   assign alu_data0_o    = data0_q;
   assign alu_data1_o    = data1_q;
   assign alu_ctrl_o     = ctrl_q;
   assign result_o       = result_q;
   assign err_o          = err_q;
   assign result_valid_o = (state_q == HOLD);
   assign timeout_o      = tmo_q;
   assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU
// attached and a reference model of command results.
module tb_alu_cmd_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] byte_i;
   logic       byte_valid_i;
   logic       byte_ready_o;
   logic [7:0] alu_data0_o;
   logic [7:0] alu_data1_o;
   logic [2:0] alu_ctrl_o;
   logic [7:0] alu_result_i;
   logic [7:0] result_o;
   logic       err_o;
   logic       result_valid_o;
   logic       result_ready_i;
   logic       timeout_o;
   logic       busy_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   alu_cmd_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .byte_i         (byte_i),
      .byte_valid_i   (byte_valid_i),
      .byte_ready_o   (byte_ready_o),
      .alu_data0_o    (alu_data0_o),
      .alu_data1_o    (alu_data1_o),
      .alu_ctrl_o     (alu_ctrl_o),
      .alu_result_i   (alu_result_i),
      .result_o       (result_o),
      .err_o          (err_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .timeout_o      (timeout_o),
      .busy_o         (busy_o)
   );

   // External combinational ALU; junk values where the ALU is undefined
   always_comb begin
      alu_result_i = 8'hA5;
      case (alu_ctrl_o)
         3'd0: alu_result_i = alu_data0_o + alu_data1_o;
         3'd1: alu_result_i = alu_data0_o - alu_data1_o;
         3'd2: alu_result_i = alu_data0_o * alu_data1_o;
         3'd3: alu_result_i = (alu_data1_o == 8'h00) ? 8'hFF : alu_data0_o / alu_data1_o;
         3'd4: alu_result_i = (alu_data1_o == 8'h00) ? 8'hFF : alu_data0_o % alu_data1_o;
         default: alu_result_i = 8'hA5;
      endcase
   end

   function automatic logic [8:0] model(input logic [7:0] op, a, b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      r  = 0;
      if (op > 8'd4) return {1'b1, 8'h00};
      if ((op == 8'd3 || op == 8'd4) && ib == 0) return {1'b1, 8'h00};
      case (op)
         8'd0: r = ia + ib;
         8'd1: r = ia - ib;
         8'd2: r = ia * ib;
         8'd3: r = ia / ib;
         default: r = ia % ib;
      endcase
      return {1'b0, 8'(r & 255)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input string tag,
                            output int t);
      bit acc;
      acc          = 1'b0;
      t            = -1;
      byte_valid_i = 1'b0;
      repeat (gap) step();
      byte_i       = b;
      byte_valid_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (byte_ready_o) begin
            acc = 1'b1;
            t   = cyc;
         end
         step();
         if (acc) break;
      end
      byte_valid_i = 1'b0;
      if (!acc) check({tag, "_accept"}, 32'(acc), 32'd1);
   endtask

   // Entered at the EXEC cycle, right after operand B was accepted
   task automatic check_result(input logic [8:0] exp, input int hold, input string tag);
      check({tag, "_exec_valid"}, 32'(result_valid_o), 32'd0);
      step();
      result_ready_i = (hold == 0);
      check({tag, "_valid"}, 32'(result_valid_o), 32'd1);
      check({tag, "_res"}, 32'(result_o), 32'(exp[7:0]));
      check({tag, "_err"}, 32'(err_o), 32'(exp[8]));
      repeat (hold) begin
         step();
         check({tag, "_hold"}, {23'd0, result_valid_o, result_o}, {23'd1, exp[7:0]});
      end
      result_ready_i = 1'b1;
      step();
      check({tag, "_done"}, 32'(result_valid_o), 32'd0);
   endtask

   task automatic run_cmd(input logic [7:0] op, a, b, input int gap, input int hold,
                          input string tag, output int t0);
      int t1, t2;
      send_byte(op, gap, {tag, "_op"}, t0);
      send_byte(a, gap, {tag, "_a"}, t1);
      send_byte(b, gap, {tag, "_b"}, t2);
      check({tag, "_ctrl"}, {alu_ctrl_o, alu_data0_o, alu_data1_o}, {op[2:0], a, b});
      check_result(model(op, a, b), hold, tag);
   endtask

   initial begin
      int t0, ta, tb;
      logic [7:0] op, a, b;
      rst_i          = 1'b1;
      byte_i         = 8'h00;
      byte_valid_i   = 1'b0;
      result_ready_i = 1'b1;
      #1;
      check("rst_ready", 32'(byte_ready_o), 32'd0);
      check("rst_outs", {alu_data0_o, alu_data1_o, result_o, 5'd0, alu_ctrl_o},
            32'd0);
      check("rst_flags", {err_o, result_valid_o, timeout_o, busy_o}, 32'd0);
      #22;
      rst_i = 1'b0;
      step();
      check("post_rst_ready", 32'(byte_ready_o), 32'd1);

      run_cmd(8'h00, 8'h25, 8'h17, 0, 0, "add", t0);
      run_cmd(8'h01, 8'h10, 8'h20, 0, 2, "sub", t0);
      run_cmd(8'h03, 8'h40, 8'h07, 0, 0, "div", t0);
      run_cmd(8'h04, 8'h11, 8'h05, 0, 0, "mod", t0);
      run_cmd(8'h03, 8'h40, 8'h00, 0, 0, "div0", t0);
      run_cmd(8'h07, 8'h01, 8'h01, 0, 0, "inv7", t0);
      run_cmd(8'h08, 8'h01, 8'h01, 0, 0, "inv8", t0);
      run_cmd(8'h02, 8'h0D, 8'h15, 0, 0, "mul", t0);

      run_cmd(8'h00, 8'h01, 8'h02, 0, 0, "thr1", ta);
      run_cmd(8'h00, 8'h03, 8'h04, 0, 0, "thr2", tb);
      check("throughput", 32'(tb - ta), 32'd5);

      // Backpressure in HOLD with a byte waiting upstream
      send_byte(8'h00, 0, "bp_op", t0);
      send_byte(8'h30, 0, "bp_a", t0);
      send_byte(8'h12, 0, "bp_b", t0);
      step();
      result_ready_i = 1'b0;
      byte_i         = 8'h02;
      byte_valid_i   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check("bp_stall", {22'd0, byte_ready_o, result_valid_o, result_o},
               {22'd1, 8'h42});
         step();
      end
      result_ready_i = 1'b1;
      step();
      check("bp_idle_ready", 32'(byte_ready_o), 32'd1);
      step();
      byte_valid_i = 1'b0;
      check("bp_opcode", {busy_o, alu_ctrl_o}, {1'b1, 3'd2});
      send_byte(8'h03, 0, "bp2_a", t0);
      send_byte(8'h04, 0, "bp2_b", t0);
      check_result({1'b0, 8'h0C}, 0, "bp2");

      // Timeout while waiting for operand B
      send_byte(8'h00, 0, "to_op", t0);
      send_byte(8'h05, 0, "to_a", t0);
      repeat (3) begin
         check("to_wait", {byte_ready_o, timeout_o}, 2'b10);
         step();
      end
      check("to_wait3", {byte_ready_o, timeout_o}, 2'b10);
      step();
      byte_i       = 8'h99;
      byte_valid_i = 1'b1;
      check("to_abort", {busy_o, byte_ready_o, timeout_o}, 3'b100);
      step();
      byte_valid_i = 1'b0;
      check("to_pulse", {busy_o, timeout_o}, 2'b01);
      step();
      check("to_pulse_end", {busy_o, timeout_o}, 2'b00);
      run_cmd(8'h02, 8'h03, 8'h04, 0, 0, "to_next", t0);

      // Asynchronous reset in GET_B
      send_byte(8'h01, 0, "rst_op", t0);
      send_byte(8'h07, 0, "rst_a", t0);
      #2;
      rst_i = 1'b1;
      #1;
      check("mid_rst_ready", 32'(byte_ready_o), 32'd0);
      check("mid_rst_outs", {alu_data0_o, alu_data1_o, result_o, 5'd0, alu_ctrl_o},
            32'd0);
      check("mid_rst_flags", {err_o, result_valid_o, timeout_o, busy_o}, 32'd0);
      #14;
      rst_i = 1'b0;
      step();
      for (int k = 0; k < 6; k++) begin
         check("mid_rst_quiet", {byte_ready_o, result_valid_o, busy_o}, 3'b100);
         step();
      end

      // Randomized commands against the reference model
      for (int n = 0; n < 40; n++) begin
         int r;
         r  = int'($urandom_range(0, 9));
         op = (r < 8) ? 8'(r) : 8'($urandom);
         a  = 8'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         run_cmd(op, a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 $sformatf("rnd%0d", n), t0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Front-end and back-end sequencer for the 8-bit combinational ALU. It accepts a byte stream over a valid/ready handshake, assembles each three-byte command (opcode, operand A, operand B), and drives the ALU operand and control inputs from registers. It captures the ALU result, flags invalid or undefined operations, and presents the result on a valid/ready output port. The block wraps the ALU on both sides: it feeds `data0_i`/`data1_i`/`ctrl_i` and consumes `result_o`.

## Interface
- `TIMEOUT_CYCLES`, default 255: idle cycles allowed between command bytes before the partial command is aborted. Range 0..65535; 0 disables the timeout.

Ports:
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `byte_i`  in  8  command byte.
- `byte_valid_i`  in  1  `byte_i` is valid.
- `byte_ready_o`  out  1  block accepts a byte. The handshake completes on a cycle where valid and ready are both 1.
- `alu_data0_o`  out  8  registered operand A, to ALU `data0_i`.
- `alu_data1_o`  out  8  registered operand B, to ALU `data1_i`.
- `alu_ctrl_o`  out  3  registered opcode, to ALU `ctrl_i`.
- `alu_result_i`  in  8  ALU `result_o`.
- `result_o`  out  8  captured result.
- `err_o`  out  1  error flag, qualified by `result_valid_o`.
- `result_valid_o`  out  1  `result_o`/`err_o` are valid.
- `result_ready_i`  in  1  consumer accepts the result.
- `timeout_o`  out  1  one-cycle pulse when a partial command is aborted.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- Opcode byte: bits [2:0] give the ALU code (000 add, 001 sub, 010 mul, 011 div, 100 mod).
- An opcode is invalid if bits [7:3] ≠ 0 or bits [2:0] > 100.
- Error rule: `err_o`=1 and `result_o`=0x00 for any of:
  - an invalid opcode;
  - div or mod with operand B = 0x00.
- Otherwise `result_o` = `alu_result_i` and `err_o` = 0.
- `alu_ctrl_o` always carries opcode bits [2:0], even when the opcode is invalid. The ALU output is ignored in that case.
- State machine:
  - IDLE: `byte_ready_o`=1. On handshake, latch `alu_ctrl_o` and the invalid-opcode flag, then go to GET_A.
  - GET_A: `byte_ready_o`=1. On handshake, latch `alu_data0_o`, then go to GET_B.
  - GET_B: `byte_ready_o`=1. On handshake, latch `alu_data1_o` and evaluate the divide-by-zero check on the incoming byte, then go to EXEC.
  - EXEC: `byte_ready_o`=0. Capture `result_o`/`err_o` (ALU inputs have been stable for one full cycle), then go to HOLD.
  - HOLD: `byte_ready_o`=0, `result_valid_o`=1. On `result_ready_i`=1, go to IDLE.
- Operand and control registers hold their last values until overwritten by the next command.
- Timeout counter (16-bit):
  - Cleared on entry to GET_A/GET_B and on every accepted byte.
  - Increments each GET_A/GET_B cycle that has no handshake.
  - When the count equals `TIMEOUT_CYCLES` (≠0): `byte_ready_o` is forced to 0 that cycle, the next state is IDLE, and `timeout_o`=1 in the first IDLE cycle.
  - A byte offered on the abort cycle is not accepted.
- Reset mid-command: the partial command is discarded and no result is emitted.
- Simultaneous `byte_valid_i` during EXEC/HOLD: the byte is not accepted and must be held by the upstream side.

## Timing
- Reset values:
  - state IDLE;
  - `alu_data0_o`, `alu_data1_o`, `result_o` = 0x00;
  - `alu_ctrl_o` = 000;
  - `err_o`, `result_valid_o`, `timeout_o`, `busy_o` = 0.
- `byte_ready_o` is 0 while `rst_i` is high; otherwise it is decoded combinationally from state.
- Latency: if operand B is accepted in cycle N, EXEC is cycle N+1 and `result_valid_o` rises in cycle N+2.
- `result_o` and `err_o` are stable throughout HOLD.
- Throughput: with no stalls, opcode/A/B are accepted in cycles 0/1/2. With `result_ready_i` held at 1, the next opcode is accepted in cycle 5, giving 5 cycles per command.
- `timeout_o` is high for exactly one cycle per abort.

## Test plan
- Reset:
  - Assert `rst_i` asynchronously mid-GET_B → all outputs take reset values immediately.
  - After release, `byte_ready_o`=1 and no stale result appears.
- Add:
  - Send 0x00, 0x25, 0x17 back-to-back → `result_o`=0x3C, `err_o`=0, `result_valid_o` two cycles after the last byte.
  - Sub: 0x01, 0x10, 0x20 → 0xF0.
- Div/mod:
  - 0x03, 0x40, 0x07 → 0x09.
  - 0x04, 0x11, 0x05 → 0x02.
  - 0x03, 0x40, 0x00 → 0x00 with `err_o`=1.
- Invalid opcodes:
  - 0x07, 0x01, 0x01 → `err_o`=1, `result_o`=0x00.
  - 0x08, 0x01, 0x01 → same.
- Backpressure:
  - Hold `result_ready_i`=0 for 10 cycles in HOLD with `byte_valid_i`=1 → result stable, `byte_ready_o`=0, no byte consumed.
  - Release → the held byte is accepted as the next opcode.
- Timeout (`TIMEOUT_CYCLES`=4):
  - Send opcode 0x00 and operand A 0x05, then stall → `timeout_o` pulses one cycle after 4 idle GET_B cycles and the state returns to IDLE.
  - The next bytes 0x02, 0x03, 0x04 → `result_o`=0x0C.
